// File: rtl/alu_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : alu_pipe_if                                                     |
// | Purpose   : Operand/opcode request channel and result channel of alu_pipe, |
// |             each with its own valid/ready handshake.                        |
// | Options   : ALU_OVF_EN adds the Overflow result flag.                       |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface alu_pipe_if #(
  parameter int WIDTH = 32
) ();
  // request channel
  logic             InValid;
  logic             InReady;
  logic [5:0]       ALUControl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  // result channel
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Illegal;
`ifdef ALU_OVF_EN
  logic             Overflow;
`endif

  // Pipeline side: issues operands, consumes results
  modport master (
    output InValid, ALUControl, A, B, OutReady,
    input  InReady, OutValid, ALUResult, Zero, Illegal
`ifdef ALU_OVF_EN
    , input Overflow
`endif
  );

  // ALU side
  modport slave (
    input  InValid, ALUControl, A, B, OutReady,
    output InReady, OutValid, ALUResult, Zero, Illegal
`ifdef ALU_OVF_EN
    , output Overflow
`endif
  );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pipe                                                         |
// | Purpose  : Handshaked EX-stage ALU. Single-cycle ops complete with latency |
// |            1; MUL runs an iterative shift-add over WIDTH cycles. Results   |
// |            sit in an output register until the consumer takes them.       |
// | Options  : ALU_OVF_EN - adds registered signed Overflow flag for ADD/SUB.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic      Clk,
  input  logic      Reset_n,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_NOR   = 6'b100111;
  localparam logic [5:0] OP_XOR   = 6'b100110;
  localparam logic [5:0] OP_SLL   = 6'b000000;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_SRA   = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SLTU  = 6'b101011;
  localparam logic [5:0] OP_MUL   = 6'b011000;
  localparam logic [5:0] OP_PASSA = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BCOND = 6'b000001;  // BGEZ when B[0]=1, BLTZ when B[0]=0
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
`ifdef ALU_OVF_EN
  logic             overflow_q, overflow_d;
`endif

  logic             can_load;
  logic             in_ready;
  logic             accept;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic             a_neg;
  logic             a_zero;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic             alu_ill;
  logic             alu_br;
  logic             alu_taken;
  logic             alu_mul;
`ifdef ALU_OVF_EN
  logic             add_ovf;
  logic             sub_ovf;
  logic             alu_ovf;
`endif

  // The output register may take a new value when empty or being drained now
  assign can_load = !out_valid_q || bus.OutReady;
  assign in_ready = (state_q == S_IDLE) && can_load;
  assign accept   = bus.InValid && in_ready;

  assign shamt   = bus.B[SHW-1:0];
  assign add_res = bus.A + bus.B;
  assign sub_res = bus.A - bus.B;
  assign a_neg   = bus.A[WIDTH-1];
  assign a_zero  = (bus.A == '0);

`ifdef ALU_OVF_EN
  // Signed overflow: result sign disagrees with what the operand signs force
  assign add_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (add_res[WIDTH-1] != bus.A[WIDTH-1]);
  assign sub_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sub_res[WIDTH-1] != bus.A[WIDTH-1]);
`endif

  // Single-cycle datapath: decode opcode, produce result and flags
  always_comb begin
    alu_res   = '0;
    alu_ill   = 1'b0;
    alu_br    = 1'b0;
    alu_taken = 1'b0;
    alu_mul   = 1'b0;
`ifdef ALU_OVF_EN
    alu_ovf   = 1'b0;
`endif
    case (bus.ALUControl)
      OP_ADD: begin
        alu_res = add_res;
`ifdef ALU_OVF_EN
        alu_ovf = add_ovf;
`endif
      end
      OP_SUB: begin
        alu_res = sub_res;
`ifdef ALU_OVF_EN
        alu_ovf = sub_ovf;
`endif
      end
      OP_AND:   alu_res = bus.A & bus.B;
      OP_OR:    alu_res = bus.A | bus.B;
      OP_NOR:   alu_res = ~(bus.A | bus.B);
      OP_XOR:   alu_res = bus.A ^ bus.B;
      OP_SLL:   alu_res = bus.A << shamt;
      OP_SRL:   alu_res = bus.A >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(bus.A) >>> shamt);
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_MUL:   alu_mul = 1'b1;
      OP_PASSA: alu_res = bus.A;
      OP_BEQ: begin
        alu_br    = 1'b1;
        alu_taken = (bus.A == bus.B);
      end
      OP_BNE: begin
        alu_br    = 1'b1;
        alu_taken = (bus.A != bus.B);
      end
      OP_BCOND: begin
        alu_br    = 1'b1;
        alu_taken = bus.B[0] ? !a_neg : a_neg;
      end
      OP_BGTZ: begin
        alu_br    = 1'b1;
        alu_taken = !a_neg && !a_zero;
      end
      OP_BLEZ: begin
        alu_br    = 1'b1;
        alu_taken = a_neg || a_zero;
      end
      default:  alu_ill = 1'b1;
    endcase
    // Branches report "taken" on Zero; illegal opcodes force Zero low
    alu_zero = alu_br ? alu_taken : (!alu_ill && (alu_res == '0));
  end

  // Control FSM, iterative multiplier and output-register next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
`ifdef ALU_OVF_EN
    overflow_d  = overflow_q;
`endif
    out_valid_d = out_valid_q && !bus.OutReady;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (alu_mul) begin
            mul_a_d = bus.A;
            mul_b_d = bus.B;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_MUL;
          end else begin
            result_d    = alu_res;
            zero_d      = alu_zero;
            illegal_d   = alu_ill;
`ifdef ALU_OVF_EN
            overflow_d  = alu_ovf;
`endif
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        // One partial product per cycle: multiplicand walks left, multiplier right
        acc_d   = acc_q + (mul_b_q[0] ? mul_a_q : '0);
        mul_a_d = mul_a_q << 1;
        mul_b_d = mul_b_q >> 1;
        cnt_d   = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (can_load) begin
          result_d    = acc_q;
          zero_d      = (acc_q == '0);
          illegal_d   = 1'b0;
`ifdef ALU_OVF_EN
          overflow_d  = 1'b0;
`endif
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any multiply in flight
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_OVF_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
`ifdef ALU_OVF_EN
      overflow_q  <= overflow_d;
`endif
    end
  end

  assign bus.InReady   = in_ready;
  assign bus.OutValid  = out_valid_q;
  assign bus.ALUResult = result_q;
  assign bus.Zero      = zero_q;
  assign bus.Illegal   = illegal_q;
`ifdef ALU_OVF_EN
  assign bus.Overflow  = overflow_q;
`endif

endmodule
`default_nettype wire
